// File: rtl/dmem_requester.sv
// dmem_requester: memory-stage data-memory request FSM (IDLE/REQ/WAIT/DONE) with read timeout; optional DMEM_BOUNDS_CHECK_EN
module dmem_requester #(
  parameter int DEPTH   = 1024,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        M_valid,
  input  logic [3:0]  M_icode,
  input  logic [63:0] M_valE,
  input  logic [63:0] M_valA,
  output logic [63:0] m_valM,
  output logic        m_stall,
  output logic        dmem_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  if (DEPTH < 1 || TIMEOUT < 1 || TIMEOUT > 15) begin : g_bad_param
    $error("dmem_requester: DEPTH must be >=1 and TIMEOUT must fit the 4-bit counter");
  end
  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d, err_q, err_d;
  logic [63:0] addr_q, addr_d, wdata_q, wdata_d, val_m_q, val_m_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        is_wr, is_rd, take, oob;
  logic [63:0] op_addr;
  // decode the memory-stage instruction and decide whether it is accepted this cycle
  always_comb begin
    is_wr   = M_icode == 4'd4 || M_icode == 4'd8 || M_icode == 4'd10;
    is_rd   = M_icode == 4'd5 || M_icode == 4'd9 || M_icode == 4'd11;
    op_addr = (M_icode == 4'd9 || M_icode == 4'd11) ? M_valA : M_valE;
`ifdef DMEM_BOUNDS_CHECK_EN
    oob     = op_addr > 64'(DEPTH - 1);
`else
    oob     = 1'b0;
`endif
    take    = state_q == IDLE && M_valid && (is_wr || is_rd);
    m_stall = (take && !oob) || state_q == REQ || state_q == WAIT;
  end
  // next-state and next-output computation
  always_comb begin
    state_d   = state_q;
    mem_req_d = mem_req_q;
    mem_we_d  = mem_we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    val_m_d   = val_m_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: if (take) begin
        state_d   = oob ? DONE : REQ;
        mem_req_d = !oob;
        mem_we_d  = is_wr;
        addr_d    = op_addr;
        wdata_d   = M_valA;
        err_d     = err_q | oob;
      end
      REQ: if (mem_ready) begin
        mem_req_d = 1'b0;
        state_d   = mem_we_q ? DONE : WAIT;
        cnt_d     = 4'd0;
      end
      WAIT: if (mem_rvalid) begin
        val_m_d = mem_rdata;
        state_d = DONE;
      end else if (cnt_q == 4'(TIMEOUT - 1)) begin
        err_d   = 1'b1;
        state_d = DONE;
      end else begin
        cnt_d   = cnt_q + 4'd1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and registered outputs, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      val_m_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      val_m_q   <= val_m_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign m_valM     = val_m_q;
  assign dmem_error = err_q;
endmodule
